spram_burst_master: RTL and testbench

//  Initiator for the single-port RAM: drives its data/addr/we pins and consumes its q output.

---
 rtl/spram_burst_master_pkg.sv | 20 ++
 rtl/single_port_ram.sv | 39 +++
 rtl/spram_burst_master_addr_gen.sv | 57 +++++
 rtl/spram_burst_master.sv | 153 +++++++++++++++
 tb/tb_spram_burst_master.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_burst_master_pkg.sv
// Shared definitions for the single-port RAM burst master and its RAM load.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spram_burst_master_pkg;

  // Default geometry shared by the burst master and single_port_ram instances.
  localparam int unsigned SPRAM_ADDR_W = 8;
  localparam int unsigned SPRAM_DATA_W = 8;
  localparam int unsigned SPRAM_DEPTH  = 64;
  localparam int unsigned SPRAM_LEN_W  = 8;

  // Burst FSM states. The encodings are fixed so that waveforms and
  // software probes read the same values everywhere.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM with a registered address: q = mem[address latched last edge].
// Latency: write lands on the clock edge; read data is valid one cycle after the address.
// Backpressure: none; the initiator re-presents the same address to hold q.
module single_port_ram
  import spram_burst_master_pkg::*;
#(
  parameter int addr_width = SPRAM_ADDR_W,
  parameter int data_width = SPRAM_DATA_W,
  parameter int depth      = SPRAM_DEPTH
) (
  input  logic                  clk,
  input  logic [data_width-1:0] data,
  input  logic [addr_width-1:0] addr,
  input  logic                  we,
  output logic [data_width-1:0] q
);

  localparam int IDX_W = (depth > 1) ? $clog2(depth) : 1;

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] addr_q;

  logic addr_in_range;
  logic addr_q_in_range;

  assign addr_in_range   = 32'(addr)   < 32'(depth);
  assign addr_q_in_range = 32'(addr_q) < 32'(depth);

  // Write port and address register; out-of-range addresses never write.
  always_ff @(posedge clk) begin
    if (we && addr_in_range) begin
      mem[addr[IDX_W-1:0]] <= data;
    end
    addr_q <= addr;
  end

  assign q = addr_q_in_range ? mem[addr_q[IDX_W-1:0]] : '0;

endmodule

// File: rtl/spram_burst_master_addr_gen.sv
// Burst address/beat counter: holds current address and remaining beats, wraps at depth.
// Latency: load and step take effect on the next clock edge; next_addr/last are combinational.
// Backpressure: none; it only advances when the caller asserts step.
module spram_burst_master_addr_gen
  import spram_burst_master_pkg::*;
#(
  parameter int addr_width = SPRAM_ADDR_W,
  parameter int depth      = SPRAM_DEPTH,
  parameter int len_width  = SPRAM_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [addr_width-1:0] load_addr,
  input  logic [len_width-1:0]  load_len,
  input  logic                  step,
  output logic [addr_width-1:0] cur_addr,
  output logic [addr_width-1:0] next_addr,
  output logic                  last
);

  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

  logic [addr_width-1:0] cur_addr_q,   cur_addr_d;
  logic [len_width-1:0]  beats_left_q, beats_left_d;

  assign next_addr = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + addr_width'(1);
  assign last      = (beats_left_q == '0);
  assign cur_addr  = cur_addr_q;

  // Load takes priority over step; beat count saturates at zero.
  always_comb begin
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    if (load) begin
      cur_addr_d   = load_addr;
      beats_left_d = load_len;
    end else if (step) begin
      cur_addr_d = next_addr;
      if (beats_left_q != '0) begin
        beats_left_d = beats_left_q - len_width'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q   <= '0;
      beats_left_q <= '0;
    end else begin
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: rtl/spram_burst_master.sv
// Burst initiator for a single-port RAM: turns (addr, len, rd/wr) commands into RAM cycles.
// Latency: write beat hits RAM the cycle it is accepted; first read beat the cycle after accept.
// Backpressure: wr_valid low or rd_ready low holds the burst; commands only accepted in IDLE.
// Optional ADDR_CHECK_EN: out-of-range start addresses are dropped and flagged on err.
module spram_burst_master
  import spram_burst_master_pkg::*;
#(
  parameter int addr_width = SPRAM_ADDR_W,
  parameter int data_width = SPRAM_DATA_W,
  parameter int depth      = SPRAM_DEPTH,
  parameter int len_width  = SPRAM_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [len_width-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [data_width-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [data_width-1:0] ram_data,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_q
`ifdef ADDR_CHECK_EN
  ,
  output logic                  err
`endif
);

  state_e state_q, state_d;

  logic                  cmd_fire;
  logic                  addr_ok;
  logic                  cmd_go;
  logic                  step;
  logic [addr_width-1:0] cur_addr;
  logic [addr_width-1:0] next_addr;
  logic                  last;

  assign cmd_fire = cmd_valid & cmd_ready;

`ifdef ADDR_CHECK_EN
  assign addr_ok = 32'(cmd_addr) < 32'(depth);
`else
  assign addr_ok = 1'b1;
`endif

  assign cmd_go = cmd_fire & addr_ok;
  assign step   = (wr_valid & wr_ready) | (rd_valid & rd_ready);

  spram_burst_master_addr_gen #(
    .addr_width (addr_width),
    .depth      (depth),
    .len_width  (len_width)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (cmd_go),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .step      (step),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .last      (last)
  );

  // Next state and handshake/RAM pin muxing. In READ the RAM address runs
  // one beat ahead on a fire, and repeats on a stall so q stays put.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cur_addr;
    ram_data  = wr_data;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        ram_addr  = cmd_addr;
        if (cmd_go) begin
          state_d = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        if (wr_valid && last) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_valid = 1'b1;
        rd_last  = last;
        if (rd_ready) begin
          ram_addr = next_addr;
          if (last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Never write the RAM while reset is being applied, even mid-burst.
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign rd_data = ram_q;

`ifdef ADDR_CHECK_EN
  logic err_q, err_d;

  // One-cycle flag for an accepted command whose start address is out of range.
  always_comb begin
    err_d = cmd_fire & ~addr_ok;
  end

  // Error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_spram_burst_master.sv
module tb_spram_burst_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic [7:0] ram_data;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
`ifdef ADDR_CHECK_EN
  logic       err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spram_burst_master #(
    .addr_width (8),
    .data_width (8),
    .depth      (64),
    .len_width  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
`ifdef ADDR_CHECK_EN
    ,
    .err       (err)
`endif
  );

  single_port_ram #(
    .addr_width (8),
    .data_width (8),
    .depth      (64)
  ) u_ram (
    .clk  (clk),
    .data (ram_data),
    .addr (ram_addr),
    .we   (ram_we),
    .q    (ram_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    settle();
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    check("ram_addr_idle", {24'd0, ram_addr}, {24'd0, a});
    check("ram_we_idle", {31'd0, ram_we}, 32'd0);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full write burst of n beats, data = base+i, addresses wrap at 64.
  task automatic write_beats(input logic [7:0] a, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      settle();
      check("wr_ready", {31'd0, wr_ready}, 32'd1);
      check("wr_busy", {31'd0, busy}, 32'd1);
      check("wr_ram_we", {31'd0, ram_we}, 32'd1);
      check("wr_ram_addr", {24'd0, ram_addr}, 32'((int'(a) + i) % 64));
      check("wr_ram_data", {24'd0, ram_data}, {24'd0, base + 8'(i)});
      tick();
    end
    wr_valid = 1'b0;
    settle();
    check("wr_done_busy", {31'd0, busy}, 32'd0);
    check("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Read burst with rd_ready held high, expecting data = base+i.
  task automatic read_beats(input int n, input logic [7:0] base);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      settle();
      check("rd_valid", {31'd0, rd_valid}, 32'd1);
      check("rd_data", {24'd0, rd_data}, {24'd0, base + 8'(i)});
      check("rd_last", {31'd0, rd_last}, (i == n - 1) ? 32'd1 : 32'd0);
      check("rd_ram_we", {31'd0, ram_we}, 32'd0);
      tick();
    end
    rd_ready = 1'b0;
    settle();
    check("rd_done_valid", {31'd0, rd_valid}, 32'd0);
    check("rd_done_busy", {31'd0, busy}, 32'd0);
  endtask

  logic       stall_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] stall_dat [6] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
  logic       stall_lst [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    tick();
    tick();
    settle();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_last", {31'd0, rd_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
`ifdef ADDR_CHECK_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
    tick();
    rst = 1'b0;

    // Write addr 4, four beats A0..A3.
    issue_cmd(1'b1, 8'd4, 8'd3);
    write_beats(8'd4, 4, 8'hA0);
    for (int i = 0; i < 4; i++) begin
      check("mem_4_7", {24'd0, u_ram.mem[4 + i]}, {24'd0, 8'hA0 + 8'(i)});
    end

    // Read it back at full rate.
    issue_cmd(1'b0, 8'd4, 8'd3);
    read_beats(4, 8'hA0);

    // Same read with a stalling consumer: data holds while rd_ready is low.
    issue_cmd(1'b0, 8'd4, 8'd3);
    for (int i = 0; i < 6; i++) begin
      rd_ready = stall_rdy[i];
      settle();
      check("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
      check("stall_rd_data", {24'd0, rd_data}, {24'd0, stall_dat[i]});
      check("stall_rd_last", {31'd0, rd_last}, {31'd0, stall_lst[i]});
      tick();
    end
    rd_ready = 1'b0;
    settle();
    check("stall_done_busy", {31'd0, busy}, 32'd0);

    // Wrapping write at 62: 62, 63, 0, 1.
    issue_cmd(1'b1, 8'd62, 8'd3);
    write_beats(8'd62, 4, 8'hB0);
    check("wrap_mem62", {24'd0, u_ram.mem[62]}, 32'hB0);
    check("wrap_mem63", {24'd0, u_ram.mem[63]}, 32'hB1);
    check("wrap_mem0", {24'd0, u_ram.mem[0]}, 32'hB2);
    check("wrap_mem1", {24'd0, u_ram.mem[1]}, 32'hB3);
    check("wrap_mem4_kept", {24'd0, u_ram.mem[4]}, 32'hA0);
    issue_cmd(1'b0, 8'd62, 8'd3);
    read_beats(4, 8'hB0);

    // Prefill 10..17 with D0..D7, then reset a C-burst after two beats.
    issue_cmd(1'b1, 8'd10, 8'd7);
    write_beats(8'd10, 8, 8'hD0);
    issue_cmd(1'b1, 8'd10, 8'd7);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hC0 + 8'(i);
      tick();
    end
    rst      = 1'b1;
    wr_data  = 8'hEE;
    settle();
    check("midrst_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_idle_we", {31'd0, ram_we}, 32'd0);
    tick();
    wr_valid = 1'b0;
    check("midrst_mem10", {24'd0, u_ram.mem[10]}, 32'hC0);
    check("midrst_mem11", {24'd0, u_ram.mem[11]}, 32'hC1);
    for (int i = 2; i < 8; i++) begin
      check("midrst_mem_kept", {24'd0, u_ram.mem[10 + i]}, {24'd0, 8'hD0 + 8'(i)});
    end

    // Single-beat read right after: last on the only beat.
    issue_cmd(1'b0, 8'd11, 8'd0);
    read_beats(1, 8'hC1);

`ifdef ADDR_CHECK_EN
    // Out-of-range start: accepted, no access, one-cycle err pulse.
    issue_cmd(1'b1, 8'd64, 8'd3);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    settle();
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_busy", {31'd0, busy}, 32'd0);
    check("oor_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    wr_valid = 1'b0;
    settle();
    check("oor_err_clear", {31'd0, err}, 32'd0);
    check("oor_ram_we2", {31'd0, ram_we}, 32'd0);
    issue_cmd(1'b0, 8'd4, 8'd0);
    read_beats(1, 8'hA0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
